if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the instruction word and PC+4 consumed by the IF_ID pipeline register. It is the producer end of that interface.
- Holds the program counter and a word-addressed instruction memory.
- Applies stall (PC hold) and branch/jump redirects, and drives the IF_ID flush request.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words.
- ADDR_BITS, 8, word-index width; must equal log2(IMEM_DEPTH).

Ports:
- clock  input  1  rising-edge clock.
- startin  input  1  asynchronous, active-high reset.
- pc_write  input  1  1 = PC may advance; 0 = stall (hold PC).
- branch_taken  input  1  redirect request from resolved branch.
- branch_target  input  32  byte address for branch redirect.
- jump  input  1  redirect request from decoded jump.
- jump_target  input  32  byte address for jump redirect.
- imem_we  input  1  instruction memory preload write enable.
- imem_waddr  input  ADDR_BITS  preload word index.
- imem_wdata  input  32  preload data.
- instruction_output  output  32  instruction at current PC, to IF_ID.
- pc_plus_4_output  output  32  current PC + 4, to IF_ID.
- pc_output  output  32  current PC.
- if_flush  output  1  request to clear IF_ID this cycle.
- fetch_count  output  32  number of PC advances since reset.
- misalign_error  output  1  sticky flag: a redirect target was misaligned.

Behaviour:
- Reset (startin=1, asynchronous, takes effect immediately, mid-operation included):
  - pc = RESET_PC, fetch_count = 0, misalign_error = 0.
  - Memory contents are NOT cleared.
  - If RESET_PC is in range, outputs reflect it immediately: pc_plus_4_output = RESET_PC+4; instruction_output = imem[RESET_PC word index].
- Read path is combinational, zero-latency:
  - instruction_output = imem[pc[ADDR_BITS+1:2]] when pc[31:ADDR_BITS+2] == 0.
  - Otherwise instruction_output = NOP (32'h0000_0000).
  - pc_plus_4_output = pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- if_flush = branch_taken | jump (combinational).
- PC update at rising clock edge, first matching rule wins:
  - branch_taken=1: pc <= {branch_target[31:2],2'b00}. Branch beats jump because the branch belongs to the older instruction.
  - jump=1: pc <= {jump_target[31:2],2'b00}.
  - pc_write=1: pc <= pc + 4 (wraps).
  - Otherwise: pc holds.
- Redirects override a stall: pc_write=0 does not block branch_taken or jump.
- fetch_count increments by 1 on every edge where pc changes by any rule above. It holds on stall and wraps at 2^32.
- misalign_error is set on an edge where the applied redirect target has bits[1:0] != 0. It stays set until reset.
- Memory write:
  - At the rising edge when imem_we=1: imem[imem_waddr] <= imem_wdata.
  - A read of the same word in that cycle returns the old data; the new data is visible after the edge.
  - Writes are allowed concurrently with fetch.
- Simultaneous branch_taken and jump: the branch target is used; if_flush=1.

Decomposition:
- Shared package (pipeline_pkg): NOP_INSTRUCTION = 32'h0000_0000, WORD_BYTES = 4, RESET_PC default.
- Sub-module instruction_memory: parameters IMEM_DEPTH and ADDR_BITS; one combinational read port and one synchronous write port; no reset.
- PC register, redirect mux, counter and error flag stay in if_fetch_unit.

Test Plan:
- Preload words 0..3 with 0xA5A5A5A5, 0x5A5A5A5A, 0xAAAAAAAA, 0xBBBBBBBB; pulse startin; pc_write=1 for 3 edges.
  - Required: pc_output 0→4→8→0xC; instruction_output follows the preloaded words; pc_plus_4_output = pc+4; fetch_count = 3.
- Stall: at pc=8, hold pc_write=0 for 2 edges.
  - Required: pc stays 8, instruction stays 0xAAAAAAAA, fetch_count unchanged. On pc_write=1, pc advances to 0xC.
- Redirect priority: at pc=4, assert branch_taken (target 0x10), jump (target 0x20) and pc_write=0 together.
  - Required: if_flush=1 during that cycle; after the edge pc=0x10 and fetch_count increments.
- Misaligned jump to 0x0000_000E.
  - Required: pc=0xC after the edge; misalign_error=1 and still 1 after 5 further cycles.
- Out-of-range and wrap: branch to 0x0000_0400 (beyond 256 words), then to 0xFFFF_FFFC, then advance.
  - Required: instruction_output=0 at out-of-range addresses; pc_plus_4_output=0 at 0xFFFF_FFFC; next pc=0.
- Mid-operation reset: assert startin asynchronously between edges while pc=0x10.
  - Required: pc_output=0, fetch_count=0, misalign_error=0 immediately. Memory still returns 0xA5A5A5A5 at word 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package pipeline_pkg;

   localparam int unsigned DATA_W           = 32;
   localparam int unsigned WORD_BYTES       = 4;
   localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Force a byte address onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: combinational read, synchronous write, no reset.
module instruction_memory
   import pipeline_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 256,
   parameter int unsigned ADDR_BITS  = 8
) (
   input  logic                 clock,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [DATA_W-1:0]    wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [DATA_W-1:0]    rdata
);

   logic [DATA_W-1:0] mem [IMEM_DEPTH];

   // Preload/update port; a same-cycle read still sees the old word.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, redirect mux, fetch counter and misalign flag.
module if_fetch_unit
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned IMEM_DEPTH = 256,
   parameter int unsigned ADDR_BITS  = 8
) (
   input  logic                 clock,
   input  logic                 startin,
   input  logic                 pc_write,
   input  logic                 branch_taken,
   input  logic [31:0]          branch_target,
   input  logic                 jump,
   input  logic [31:0]          jump_target,
   input  logic                 imem_we,
   input  logic [ADDR_BITS-1:0] imem_waddr,
   input  logic [31:0]          imem_wdata,
   output logic [31:0]          instruction_output,
   output logic [31:0]          pc_plus_4_output,
   output logic [31:0]          pc_output,
   output logic                 if_flush,
   output logic [31:0]          fetch_count,
   output logic                 misalign_error
);

   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        advance;
   logic        bad_target;
   logic        in_range;
   logic [31:0] imem_rdata;

   instruction_memory #(
      .IMEM_DEPTH (IMEM_DEPTH),
      .ADDR_BITS  (ADDR_BITS)
   ) u_imem (
      .clock (clock),
      .we    (imem_we),
      .waddr (imem_waddr),
      .wdata (imem_wdata),
      .raddr (pc[ADDR_BITS+1:2]),
      .rdata (imem_rdata)
   );

   // Next-PC selection: older branch beats jump, any redirect beats a stall.
   always_comb begin
      next_pc    = pc;
      advance    = 1'b0;
      bad_target = 1'b0;
      if (branch_taken) begin
         next_pc    = word_align(branch_target);
         advance    = 1'b1;
         bad_target = |branch_target[1:0];
      end else if (jump) begin
         next_pc    = word_align(jump_target);
         advance    = 1'b1;
         bad_target = |jump_target[1:0];
      end else if (pc_write) begin
         next_pc    = pc + 32'(WORD_BYTES);
         advance    = 1'b1;
      end
   end

   // PC, fetch counter and sticky misalign flag.
   always_ff @(posedge clock or posedge startin) begin
      if (startin) begin
         pc             <= RESET_PC;
         fetch_count    <= 32'd0;
         misalign_error <= 1'b0;
      end else begin
         pc <= next_pc;
         if (advance) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if (bad_target) begin
            misalign_error <= 1'b1;
         end
      end
   end

   // Zero-latency read path; addresses beyond the memory fetch a NOP.
   assign in_range           = (pc[31:ADDR_BITS+2] == '0);
   assign instruction_output = in_range ? imem_rdata : NOP_INSTRUCTION;
   assign pc_plus_4_output   = pc + 32'(WORD_BYTES);
   assign pc_output          = pc;
   assign if_flush           = branch_taken | jump;

endmodule
